// File: rtl/fnd_scan_controller.sv
// 4-digit common-anode 7-segment scan controller. It latches all four digits once per frame,
// suppresses leading zeros, and adds a dark guard interval at the start of each digit slot.
module fnd_scan_controller #(
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter bit          LZ_BLANK     = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_enable,
  input  logic [3:0] i_1000_value,
  input  logic [3:0] i_100_value,
  input  logic [3:0] i_10_value,
  input  logic [3:0] i_1_value,
  input  logic [3:0] i_dp_mask,
  output logic [3:0] o_fndDigit,
  output logic [7:0] o_fndFont,
  output logic       o_frame_done
);

  localparam int unsigned CntW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     shadow_q, shadow_d;
  logic [3:0]      dp_q, dp_d;
  logic [3:0]      digit_q, digit_d;
  logic [7:0]      font_q, font_d;
  logic            frame_done_q, frame_done_d;

  logic       wrap;
  logic       guard;
  logic [3:0] cur_val;
  logic [3:0] blank;
  logic [6:0] seg;

  assign wrap  = (cnt_q == CntMax);
  assign guard = (32'(cnt_q) < BLANK_CYCLES);

  // Leading-zero chain: a digit can only blank if every digit to its left is blank.
  always_comb begin
    blank    = 4'b0000;
    blank[3] = LZ_BLANK && (shadow_q[15:12] == 4'h0);
    blank[2] = blank[3] && (shadow_q[11:8] == 4'h0);
    blank[1] = blank[2] && (shadow_q[7:4] == 4'h0);
  end

  always_comb begin
    cur_val = shadow_q[3:0];
    unique case (idx_q)
      2'd0: cur_val = shadow_q[3:0];
      2'd1: cur_val = shadow_q[7:4];
      2'd2: cur_val = shadow_q[11:8];
      2'd3: cur_val = shadow_q[15:12];
      default: cur_val = shadow_q[3:0];
    endcase
  end

  always_comb begin
    seg = 7'h7F;
    case (cur_val)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    dp_d         = dp_q;
    frame_done_d = 1'b0;
    digit_d      = 4'hF;
    font_d       = 8'hFF;
    if (!i_enable) begin
      // Track inputs while dark so the first frame after enable shows current values.
      cnt_d    = '0;
      idx_d    = 2'd0;
      shadow_d = {i_1000_value, i_100_value, i_10_value, i_1_value};
      dp_d     = i_dp_mask;
    end else begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      idx_d = wrap ? idx_q + 2'd1 : idx_q;
      if (wrap && (idx_q == 2'd3)) begin
        shadow_d     = {i_1000_value, i_100_value, i_10_value, i_1_value};
        dp_d         = i_dp_mask;
        frame_done_d = 1'b1;
      end
      if (!guard) begin
        digit_d = ~(4'b0001 << idx_q);
        font_d  = {~dp_q[idx_q], blank[idx_q] ? 7'h7F : seg};
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      shadow_q     <= 16'h0000;
      dp_q         <= 4'h0;
      digit_q      <= 4'hF;
      font_q       <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      dp_q         <= dp_d;
      digit_q      <= digit_d;
      font_q       <= font_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_fndDigit   = digit_q;
  assign o_fndFont    = font_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller with an 8-cycle slot and a 2-cycle guard interval.
// Edge e after reset release shows cnt=(e-1)%8 and idx=((e-1)/8)%4.
module tb_fnd_scan_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [3:0] d1000, d100, d10, d1, dp_mask;
  logic [3:0] fnd_digit;
  logic [7:0] fnd_font;
  logic       frame_done;

  int total = 0;
  int bad   = 0;
  int e     = 0;

  fnd_scan_controller #(
    .TICK_DIV    (8),
    .BLANK_CYCLES(2),
    .LZ_BLANK    (1'b1)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .i_enable    (enable),
    .i_1000_value(d1000),
    .i_100_value (d100),
    .i_10_value  (d10),
    .i_1_value   (d1),
    .i_dp_mask   (dp_mask),
    .o_fndDigit  (fnd_digit),
    .o_fndFont   (fnd_font),
    .o_frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at e=%0d: got %02h expected %02h", tag, e, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic run_to(input int target);
    while (e < target) tick();
  endtask

  task automatic set_digits(input logic [3:0] a, b, c, d);
    d1000 = a; d100 = b; d10 = c; d1 = d;
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b1;
    dp_mask = 4'h0;
    set_digits(4'h0, 4'h0, 4'h0, 4'h3);
    repeat (3) @(posedge clk);
    #1;
    check("rst_digit", {4'h0, fnd_digit}, 8'h0F);
    check("rst_font", fnd_font, 8'hFF);
    check("rst_fdone", {7'h0, frame_done}, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;

    // First frame shows the reset shadow (all zeros): only the ones digit is lit.
    run_to(1);  check("guard1_digit", {4'h0, fnd_digit}, 8'h0F);
    run_to(2);  check("guard2_font", fnd_font, 8'hFF);
    run_to(3);  check("on_first_digit", {4'h0, fnd_digit}, 8'h0E);
                check("on_first_font", fnd_font, 8'hC0);
    run_to(8);  check("on_last_digit", {4'h0, fnd_digit}, 8'h0E);
    run_to(9);  check("slot1_guard", {4'h0, fnd_digit}, 8'h0F);
    run_to(11); check("slot1_digit", {4'h0, fnd_digit}, 8'h0D);
                check("slot1_blank", fnd_font, 8'hFF);
    run_to(31); check("fdone_before", {7'h0, frame_done}, 8'h00);
    run_to(32); check("fdone_pulse1", {7'h0, frame_done}, 8'h01);
    run_to(33); check("fdone_after", {7'h0, frame_done}, 8'h00);

    // Frame 2 displays 0,0,0,3 latched at e=32.
    run_to(35); check("f3_ones_digit", {4'h0, fnd_digit}, 8'h0E);
                check("f3_ones_font", fnd_font, 8'hB0);
    run_to(40); set_digits(4'h1, 4'h0, 4'h2, 4'h0);
    run_to(43); check("f3_tens", {fnd_digit, fnd_font[7:4]}, 8'hDF);
                check("f3_tens_font", fnd_font, 8'hFF);
    run_to(51); check("f3_hund_digit", {4'h0, fnd_digit}, 8'h0B);
                check("f3_hund_font", fnd_font, 8'hFF);
    run_to(59); check("f3_thou_digit", {4'h0, fnd_digit}, 8'h07);
                check("f3_thou_font", fnd_font, 8'hFF);
    run_to(63); check("fdone_63", {7'h0, frame_done}, 8'h00);
    run_to(64); check("fdone_pulse2", {7'h0, frame_done}, 8'h01);

    // Frame 3: 1,0,2,0 -- the hundreds zero is not leading.
    run_to(67); check("f1020_ones", fnd_font, 8'hC0);
    run_to(75); check("f1020_tens", fnd_font, 8'hA4);
    run_to(83); check("f1020_hund", fnd_font, 8'hC0);
    run_to(91); check("f1020_thou", fnd_font, 8'hF9);
                check("f1020_thou_d", {4'h0, fnd_digit}, 8'h07);

    // Frame 4: ones digit 1; the change to 2 in slot 1 must wait for the next latch.
    run_to(92);  set_digits(4'h0, 4'h0, 4'h0, 4'h1);
    run_to(99);  check("f1_ones", fnd_font, 8'hF9);
    run_to(106); set_digits(4'h0, 4'h0, 4'h0, 4'h2);
    run_to(107); check("f1_tens_hold", fnd_font, 8'hFF);
    run_to(128); check("fdone_pulse4", {7'h0, frame_done}, 8'h01);
    run_to(131); check("f2_ones", fnd_font, 8'hA4);

    // Blanked digit keeps its decimal point.
    run_to(132); set_digits(4'h0, 4'h0, 4'h0, 4'h0); dp_mask = 4'b0010;
    run_to(163); check("dp_ones", fnd_font, 8'hC0);
    run_to(171); check("dp_tens_digit", {4'h0, fnd_digit}, 8'h0D);
                 check("dp_tens_font", fnd_font, 8'h7F);
    run_to(179); check("dp_hund_font", fnd_font, 8'hFF);

    // Drop enable in the middle of slot 2.
    run_to(212); check("pre_dis_digit", {4'h0, fnd_digit}, 8'h0B);
    enable = 1'b0;
    set_digits(4'h0, 4'h0, 4'h0, 4'h5); dp_mask = 4'h0;
    run_to(213); check("dis_digit", {4'h0, fnd_digit}, 8'h0F);
                 check("dis_font", fnd_font, 8'hFF);
    run_to(220); check("dis_fdone", {7'h0, frame_done}, 8'h00);
    enable = 1'b1;
    run_to(221); check("reen_guard1", {fnd_digit, fnd_font[7:4]}, 8'hFF);
    run_to(222); check("reen_guard2", {fnd_digit, fnd_font[7:4]}, 8'hFF);
    run_to(223); check("reen_digit", {4'h0, fnd_digit}, 8'h0E);
                 check("reen_font", fnd_font, 8'h92);

    // Asynchronous reset in the middle of an ON slot.
    run_to(225);
    reset_n = 1'b0;
    #1;
    check("async_digit", {4'h0, fnd_digit}, 8'h0F);
    check("async_font", fnd_font, 8'hFF);
    check("async_fdone", {7'h0, frame_done}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
